// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank: opcodes, widths and state encoding.
package reg_bank_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_COUNT = 8;
    localparam int IDX_W     = 3;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_CLR  = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_ADD  = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWAP2 = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational arithmetic for INC/DEC/ADD; result and flags are only consumed for those opcodes.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_INC: begin
                sum    = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_DEC: begin
                // borrow happens exactly when the operand was zero
                result = a - {{(WIDTH-1){1'b0}}, 1'b1};
                carry  = (a == '0);
            end
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            default: begin
                result = a;
                carry  = 1'b0;
            end
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/register_bank.sv
// Eight-entry architectural register bank with a single write port, command decode and two-cycle SWAP.
module register_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = REG_COUNT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VALID,
    input  logic [2:0]       OP,
    input  logic [2:0]       DST,
    input  logic [2:0]       SRC,
    input  logic [WIDTH-1:0] DIN,
    output logic             BUSY,
    output logic             DONE,
    output logic             CARRY,
    output logic             ZERO,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] R3,
    output logic [WIDTH-1:0] R4,
    output logic [WIDTH-1:0] R5,
    output logic [WIDTH-1:0] R6,
    output logic [WIDTH-1:0] R7
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] temp;
    logic [IDX_W-1:0] swap_dst;
    state_t           state;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;

    reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (OP),
        .a      (regs[DST]),
        .b      (regs[SRC]),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            temp     <= '0;
            swap_dst <= '0;
            CARRY    <= 1'b0;
            ZERO     <= 1'b0;
            DONE     <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (VALID) begin
                        DONE <= (OP != OP_SWAP);
                        case (OP)
                            OP_LOAD: regs[DST] <= DIN;
                            OP_INC, OP_DEC, OP_ADD: begin
                                regs[DST] <= alu_result;
                                CARRY     <= alu_carry;
                                ZERO      <= alu_zero;
                            end
                            OP_CLR:  regs[DST] <= '0;
                            OP_MOV:  regs[DST] <= regs[SRC];
                            OP_SWAP: begin
                                // first half: park SRC, overwrite it with DST
                                temp      <= regs[SRC];
                                regs[SRC] <= regs[DST];
                                swap_dst  <= DST;
                                state     <= ST_SWAP2;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SWAP2: begin
                    regs[swap_dst] <= temp;
                    DONE           <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY = (state == ST_SWAP2);

    assign R0 = regs[0];
    assign R1 = regs[1];
    assign R2 = regs[2];
    assign R3 = regs[3];
    assign R4 = regs[4];
    assign R5 = regs[5];
    assign R6 = regs[6];
    assign R7 = regs[7];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus random commands against an array model.
module tb_register_bank;

    logic       CLK;
    logic       RESET;
    logic       VALID;
    logic [2:0] OP, DST, SRC;
    logic [7:0] DIN;
    logic       BUSY, DONE, CARRY, ZERO;
    logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int  m [8];
    bit  m_carry, m_zero, m_busy, m_done;
    int  m_temp, m_dst;

    register_bank dut (
        .CLK(CLK), .RESET(RESET), .VALID(VALID), .OP(OP), .DST(DST), .SRC(SRC), .DIN(DIN),
        .BUSY(BUSY), .DONE(DONE), .CARRY(CARRY), .ZERO(ZERO),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] get_r(int i);
        case (i)
            0: return R0;
            1: return R1;
            2: return R2;
            3: return R3;
            4: return R4;
            5: return R5;
            6: return R6;
            default: return R7;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit v, input int op, input int d, input int s, input int din);
        int sum;
        if (rst) begin
            for (int i = 0; i < 8; i++) m[i] = 0;
            m_carry = 0; m_zero = 0; m_busy = 0; m_done = 0; m_temp = 0;
        end else if (m_busy) begin
            m[m_dst] = m_temp;
            m_busy = 0;
            m_done = 1;
        end else begin
            m_done = 0;
            if (v) begin
                m_done = (op != 6);
                case (op)
                    1: m[d] = din;
                    2: begin m_carry = (m[d] == 255); m[d] = (m[d] + 1) % 256; m_zero = (m[d] == 0); end
                    3: begin m_carry = (m[d] == 0); m[d] = (m[d] + 255) % 256; m_zero = (m[d] == 0); end
                    4: m[d] = 0;
                    5: m[d] = m[s];
                    6: begin m_temp = m[s]; m[s] = m[d]; m_dst = d; m_busy = 1; end
                    7: begin sum = m[d] + m[s]; m_carry = (sum > 255); m[d] = sum % 256; m_zero = (m[d] == 0); end
                    default: ;
                endcase
            end
        end
    endtask

    // drive at the falling edge, clock, update model, return at the next falling edge
    task automatic step(input bit rst, input bit v, input int op, input int d, input int s, input int din);
        RESET = rst; VALID = v; OP = 3'(op); DST = 3'(d); SRC = 3'(s); DIN = 8'(din);
        @(posedge CLK);
        model_edge(rst, v, op, d, s, din);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        RESET = 0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (get_r(i) !== 8'h00) begin errors++; $display("FAIL reset_r%0d got %h want 00", i, get_r(i)); end
        end
        checks++;
        if ({CARRY, ZERO, BUSY, DONE} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl got c%b z%b b%b d%b want 0000", CARRY, ZERO, BUSY, DONE);
        end
    endtask

    task automatic test_load_mov();
        step(0, 1, 1, 3, 0, 8'hA5);
        checks++;
        if (R3 !== 8'hA5 || DONE !== 1'b1) begin errors++; $display("FAIL load_r3 got %h done %b want a5 1", R3, DONE); end
        step(0, 1, 5, 6, 3, 0);
        checks++;
        if (R6 !== 8'hA5 || DONE !== 1'b1) begin errors++; $display("FAIL mov_r6 got %h done %b want a5 1", R6, DONE); end
        checks++;
        if (CARRY !== m_carry || ZERO !== m_zero) begin
            errors++; $display("FAIL mov_flags got c%b z%b want c%b z%b", CARRY, ZERO, m_carry, m_zero);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (DONE !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", DONE); end
    endtask

    task automatic test_inc_dec_wrap();
        step(0, 1, 1, 1, 0, 8'hFF);
        step(0, 1, 2, 1, 0, 0);
        checks++;
        if (R1 !== 8'h00 || CARRY !== 1'b1 || ZERO !== 1'b1) begin
            errors++; $display("FAIL inc_wrap got %h c%b z%b want 00 c1 z1", R1, CARRY, ZERO);
        end
        step(0, 1, 3, 1, 0, 0);
        checks++;
        if (R1 !== 8'hFF || CARRY !== 1'b1 || ZERO !== 1'b0) begin
            errors++; $display("FAIL dec_wrap got %h c%b z%b want ff c1 z0", R1, CARRY, ZERO);
        end
    endtask

    task automatic test_add();
        step(0, 1, 1, 2, 0, 8'h80);
        step(0, 1, 1, 4, 0, 8'h90);
        step(0, 1, 7, 2, 4, 0);
        checks++;
        if (R2 !== 8'h10 || CARRY !== 1'b1 || ZERO !== 1'b0) begin
            errors++; $display("FAIL add_carry got %h c%b z%b want 10 c1 z0", R2, CARRY, ZERO);
        end
        step(0, 1, 1, 5, 0, 8'h00);
        step(0, 1, 7, 5, 5, 0);
        checks++;
        if (R5 !== 8'h00 || CARRY !== 1'b0 || ZERO !== 1'b1) begin
            errors++; $display("FAIL add_self_zero got %h c%b z%b want 00 c0 z1", R5, CARRY, ZERO);
        end
    endtask

    task automatic test_swap_busy();
        step(0, 1, 1, 0, 0, 8'h11);
        step(0, 1, 1, 7, 0, 8'h22);
        step(0, 1, 6, 0, 7, 0);
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin errors++; $display("FAIL swap_busy got b%b d%b want b1 d0", BUSY, DONE); end
        step(0, 1, 1, 0, 0, 8'hEE);
        checks++;
        if (R0 !== 8'h22 || R7 !== 8'h11 || DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL swap_done got r0 %h r7 %h d%b b%b want 22 11 1 0", R0, R7, DONE, BUSY);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (R0 !== 8'h22 || DONE !== 1'b0) begin errors++; $display("FAIL swap_after got r0 %h d%b want 22 0", R0, DONE); end
    endtask

    task automatic test_reset_mid_swap();
        step(0, 1, 1, 0, 0, 8'h11);
        step(0, 1, 1, 7, 0, 8'h22);
        step(0, 1, 6, 0, 7, 0);
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (R0 !== 8'h00 || R7 !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++; $display("FAIL mid_swap_reset got r0 %h r7 %h b%b d%b want 00 00 0 0", R0, R7, BUSY, DONE);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (R0 !== 8'h00 || DONE !== 1'b0) begin errors++; $display("FAIL mid_swap_after got r0 %h d%b want 00 0", R0, DONE); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (get_r(i) !== 8'(m[i])) begin
                    errors++; $display("FAIL rand_r%0d cyc %0d got %h want %h", i, n, get_r(i), 8'(m[i]));
                end
            end
            checks++;
            if ({CARRY, ZERO, BUSY, DONE} !== {m_carry, m_zero, m_busy, m_done}) begin
                errors++; $display("FAIL rand_ctl cyc %0d got %b want %b", n, {CARRY, ZERO, BUSY, DONE},
                                   {m_carry, m_zero, m_busy, m_done});
            end
        end
    endtask

    initial begin
        RESET = 1; VALID = 0; OP = 0; DST = 0; SRC = 0; DIN = 0;
        @(negedge CLK);
        test_reset();
        test_load_mov();
        test_inc_dec_wrap();
        test_add();
        test_swap_busy();
        test_reset_mid_swap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
